// File: rtl/switch_debounce.sv
// switch_debounce -- per-channel switch debouncer.
//
// Each raw input bit is brought into the clk domain through a two-flop
// synchronizer. A per-channel counter then measures how long the
// synchronized level has disagreed with the debounced output. The output
// only adopts the new level after DEBOUNCE_CYCLES consecutive disagreeing
// edges.
//
// Optional feature: define SWITCH_DEBOUNCE_EDGE_EN to get registered
// one-cycle O_RISE / O_FALL pulses. Without the macro, both ports stay
// present but are tied to zero, and no edge registers are built.
//
// Reset (rst_n) is synchronous and active-low. It clears every register,
// including the synchronizer.

module switch_debounce #(
    parameter int NSWITCH         = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSWITCH-1:0] I,
    output logic [NSWITCH-1:0] O,
    output logic [NSWITCH-1:0] O_RISE,
    output logic [NSWITCH-1:0] O_FALL
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1. This width also
    // covers DEBOUNCE_CYCLES itself, so the terminal value is always
    // representable.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NSWITCH-1:0] s1_p0;
    logic [NSWITCH-1:0] s2_p1;
    logic [CNT_W-1:0]   cnt     [NSWITCH];
    logic [CNT_W-1:0]   cnt_d   [NSWITCH];
    logic [NSWITCH-1:0] differ;
    logic [NSWITCH-1:0] commit;

    // The next count follows three cases:
    //   - agreement clears the count;
    //   - reaching the terminal count clears it, because the output commits;
    //   - otherwise the count steps up by one.
    // Because the terminal value resets the count, the counter can never
    // pass CNT_LAST or wrap.
    function automatic logic [CNT_W-1:0] next_count(input logic             dis,
                                                    input logic [CNT_W-1:0] c);
        if (!dis || (c == CNT_LAST)) begin
            return '0;
        end
        return c + 1'b1;
    endfunction

    // The output commits on the edge that completes the required run of
    // disagreeing samples.
    function automatic logic commits(input logic             dis,
                                     input logic [CNT_W-1:0] c);
        return dis && (c == CNT_LAST);
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous switch levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_p0 <= '0;
            s2_p1 <= '0;
        end else begin
            s1_p0 <= I;
            s2_p1 <= s1_p0;
        end
    end

    // Per-channel compare of the synchronized level against the debounced output
    always_comb begin
        differ = '0;
        commit = '0;
        for (int i = 0; i < NSWITCH; i++) begin
            cnt_d[i]  = '0;
            differ[i] = s2_p1[i] ^ O[i];
            commit[i] = commits(differ[i], cnt[i]);
            cnt_d[i]  = next_count(differ[i], cnt[i]);
        end
    end

    // Stage p2: stability counters and debounced output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSWITCH; i++) begin
                cnt[i] <= '0;
            end
            O <= '0;
        end else begin
            for (int i = 0; i < NSWITCH; i++) begin
                cnt[i] <= cnt_d[i];
            end
            O <= (O & ~commit) | (s2_p1 & commit);
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [NSWITCH-1:0] rise_p2;
    logic [NSWITCH-1:0] fall_p2;

    // Edge pulses are registered on the same edge as the O change, so they
    // line up with the new O value and last exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_p2 <= '0;
            fall_p2 <= '0;
        end else begin
            rise_p2 <= commit &  s2_p1;
            fall_p2 <= commit & ~s2_p1;
        end
    end

    assign O_RISE = rise_p2;
    assign O_FALL = fall_p2;
`else
    assign O_RISE = '0;
    assign O_FALL = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce -- self-checking bench for switch_debounce.
//
// Two instances are used:
//   dut_a: 4 channels, DEBOUNCE_CYCLES = 4.
//   dut_b: 2 channels, DEBOUNCE_CYCLES = 1.
//
// The reference model works from the behavioural rule, not from the RTL's
// counter. A synchronized sample stream (two edges behind I) is kept per
// channel. The output flips once the last DEBOUNCE_CYCLES samples all
// disagree with it, provided that many edges have passed since its last
// flip or since reset.

module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ia;
    logic [3:0] oa, ra, fa;
    logic [1:0] ib;
    logic [1:0] ob, rb, fb;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    always #5 clk = ~clk;

    switch_debounce #(.NSWITCH(4), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .I(ia), .O(oa), .O_RISE(ra), .O_FALL(fa)
    );

    switch_debounce #(.NSWITCH(2), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .I(ib), .O(ob), .O_RISE(rb), .O_FALL(fb)
    );

    // ---------------- behavioural model ----------------
    int       dcv [2] = '{4, 1};
    int       nch [2] = '{4, 2};
    bit       m_s1 [2][4];
    bit       m_s2 [2][4];
    bit       m_o  [2][4];
    bit       m_r  [2][4];
    bit       m_f  [2][4];
    int       m_since [2][4];
    bit [7:0] m_win [2][4];

    always @(posedge clk) begin
        logic [3:0] inv;
        bit         all_dis;
        bit         flip;
        for (int d = 0; d < 2; d++) begin
            inv = (d == 0) ? ia : {2'b00, ib};
            for (int c = 0; c < nch[d]; c++) begin
                if (!rst_n) begin
                    m_s1[d][c]    = 1'b0;
                    m_s2[d][c]    = 1'b0;
                    m_o[d][c]     = 1'b0;
                    m_r[d][c]     = 1'b0;
                    m_f[d][c]     = 1'b0;
                    m_since[d][c] = 0;
                    m_win[d][c]   = '0;
                end else begin
                    m_win[d][c] = {m_win[d][c][6:0], m_s2[d][c]};
                    if (m_since[d][c] < 1000) m_since[d][c]++;
                    all_dis = 1'b1;
                    for (int j = 0; j < dcv[d]; j++)
                        if (m_win[d][c][j] == m_o[d][c]) all_dis = 1'b0;
                    flip = (m_since[d][c] >= dcv[d]) && all_dis;
                    m_r[d][c] = flip && !m_o[d][c];
                    m_f[d][c] = flip &&  m_o[d][c];
                    if (flip) begin
                        m_o[d][c]     = !m_o[d][c];
                        m_since[d][c] = 0;
                    end
                    m_s2[d][c] = m_s1[d][c];
                    m_s1[d][c] = inv[c];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pk(input int d, input int sel);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < nch[d]; c++) begin
            case (sel)
                0:       v[c] = m_o[d][c];
                1:       v[c] = EDGE_EN & m_r[d][c];
                default: v[c] = EDGE_EN & m_f[d][c];
            endcase
        end
        return v;
    endfunction

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run_chk) begin
            chk("a_O",      {28'd0, oa}, {28'd0, pk(0, 0)});
            chk("a_O_RISE", {28'd0, ra}, {28'd0, pk(0, 1)});
            chk("a_O_FALL", {28'd0, fa}, {28'd0, pk(0, 2)});
            chk("b_O",      {30'd0, ob}, {28'd0, pk(1, 0)});
            chk("b_O_RISE", {30'd0, rb}, {28'd0, pk(1, 1)});
            chk("b_O_FALL", {30'd0, fb}, {28'd0, pk(1, 2)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ia    = '0;
        ib    = '0;
        tick();
        tick();
        run_chk = 1'b1;

        // Reset state
        chk("rst_O",    {28'd0, oa}, 32'd0);
        chk("rst_RISE", {28'd0, ra}, 32'd0);
        chk("rst_FALL", {28'd0, fa}, 32'd0);
        chk("rst_bO",   {30'd0, ob}, 32'd0);
        chk("rst_model", {31'd0, m_o[0][0]}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single rise: O=1 from edge 6, one rise pulse
        ia = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("rise_O",     {31'd0, oa[0]},     {31'd0, e >= 6});
            chk("rise_model", {31'd0, m_o[0][0]}, {31'd0, e >= 6});
            chk("rise_pulse", {31'd0, ra[0]},     {31'd0, EDGE_EN && (e == 6)});
            chk("rise_nofall", {31'd0, fa[0]},    32'd0);
        end

        // 3-cycle glitch on channel 1 is rejected
        ia = 4'b0011;
        for (int e = 1; e <= 13; e++) begin
            if (e == 4) ia = 4'b0001;
            tick();
            chk("glitch_O",    {31'd0, oa[1]}, 32'd0);
            chk("glitch_rise", {31'd0, ra[1]}, 32'd0);
        end

        // Simultaneous rise on channels 2 and 3
        ia = 4'b1101;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("simul_O",    {30'd0, oa[3:2]}, (e >= 6) ? 32'd3 : 32'd0);
            chk("simul_rise", {30'd0, ra[3:2]}, (EDGE_EN && e == 6) ? 32'd3 : 32'd0);
        end

        // Reset mid-debounce discards the partial count
        ia = 4'b0000;
        repeat (12) tick();
        ia = 4'b0001;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_O",    {28'd0, oa}, 32'd0);
        chk("midrst_rise", {28'd0, ra}, 32'd0);
        chk("midrst_fall", {28'd0, fa}, 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("postrst_O",    {31'd0, oa[0]}, {31'd0, e >= 6});
            chk("postrst_rise", {31'd0, ra[0]}, {31'd0, EDGE_EN && (e == 6)});
        end

        // DEBOUNCE_CYCLES=1: three-edge latency, alternating pulses
        for (int k = 0; k < 3; k++) begin
            ib = 2'b01;
            for (int e = 1; e <= 4; e++) begin
                tick();
                chk("dc1_O_hi", {31'd0, ob[0]}, {31'd0, e >= 3});
                chk("dc1_rise", {31'd0, rb[0]}, {31'd0, EDGE_EN && (e == 3)});
            end
            ib = 2'b00;
            for (int e = 1; e <= 4; e++) begin
                tick();
                chk("dc1_O_lo", {31'd0, ob[0]}, {31'd0, e < 3});
                chk("dc1_fall", {31'd0, fb[0]}, {31'd0, EDGE_EN && (e == 3)});
            end
        end

        // Randomized phase with occasional resets, checked by the model
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) ia[c] = ~ia[c];
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 2) == 0) ib[c] = ~ib[c];
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (10) tick();
        run_chk = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
